bitwise_result_fifo: RTL
========================

# bitwise_result_fifo

Downstream capture stage for the 4-bit bitwise operation unit. Each cycle that unit presents all five results at once (d0=~x, d1=x&y, d2=x|y, d3=x^y, d4=x~^y). This block selects one result per accepted transfer by opcode and queues it, with its opcode, in a small first-word-fall-through FIFO behind a valid/ready handshake. It also keeps a running XOR checksum of delivered results and a sticky illegal-opcode flag for the bench and debug readout.

## Interface
- WIDTH, 4, bit width of each result, matching the operation unit's 4-bit operands.
- DEPTH, 4, number of FIFO entries; must be a power of two, ≥2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately and releases synchronously to clk.
- d0, d1, d2, d3, d4  input  WIDTH each  result bus from the operation unit.
- in_valid  input  1  upstream holds a result set and opcode.
- in_op  input  3  result select: 0→d0, 1→d1, 2→d2, 3→d3, 4→d4; 5–7 are illegal.
- in_ready  output  1  block can accept; equals !full.
- out_valid  output  1  head entry present; equals !empty.
- out_data  output  WIDTH  head entry result.
- out_op  output  3  head entry opcode.
- out_ready  input  1  downstream consumes the head.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- checksum  output  WIDTH  XOR of every out_data popped since reset.
- err_op  output  1  sticky; set on any accepted transfer with in_op > 4.

## Operation
- Push: in_valid && in_ready. If in_op ≤ 4, write {in_op, d[in_op]} at the write pointer, advance it, and increment count.
- Illegal opcode push: the handshake completes, nothing is written, count is unchanged, and err_op is set to 1. Only reset clears err_op.
- Pop: out_valid && out_ready. Advance the read pointer, decrement count, and set checksum ← checksum ^ out_data.
- Simultaneous push and pop when not full and not empty: both take effect and count is unchanged.
- Full (count==DEPTH): in_ready=0, so no push occurs even if a pop happens the same cycle. There is no bypass.
- Empty (count==0): out_valid=0, out_data/out_op hold the last head value (don't-care), and out_ready is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is decided from count only.
- Storage holds no reset requirement. Pointers, count, checksum and err_op all reset to 0.
- Reset mid-operation drops all queued entries immediately. out_valid falls asynchronously with rst_n.

## Timing
- Reset values: in_ready=1 once rst_n is high, out_valid=0, count=0, checksum=0, err_op=0, out_data/out_op=0.
- in_ready and out_valid are registered-derived (from count only). There is no combinational path from in_valid/out_ready to any output.
- Latency: a push at edge N into an empty FIFO gives out_valid=1 and the entry visible on out_data after edge N.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- checksum and err_op update on the same edge as the pop or push that causes them.

## Test plan
- Basic path: x=1010, y=1110 (d0=0101, d1=1010, d2=1110, d3=0100, d4=1011). Push ops 0..3 with out_ready=0. Required: count=4, in_ready=0. Then out_ready=1 for 4 cycles. Required: pops 0101/0, 1010/1, 1110/2, 0100/3 in order, then checksum=0101^1010^1110^0100=0101 and out_valid=0.
- Full back-pressure: with the FIFO full, hold in_valid=1, in_op=4 and pop once. Required: the head pops, count=3 on that edge, and the op-4 entry (1011) is accepted on the following edge.
- Illegal opcode: push in_op=6 into an empty FIFO. Required: count stays 0, out_valid=0, err_op=1 and still 1 after 10 further legal transfers.
- Streaming: in_valid=1 and out_ready=1 every cycle for 12 cycles, op cycling 0..4. Required: count settles at 1, each result appears one cycle after its push, and pointers wrap with no loss or duplication.
- Reset mid-operation: fill 3 entries, drop rst_n mid-cycle. Required: out_valid=0 and count=0 immediately, with checksum=0 and err_op=0. After release, the first push of in_op=2 pops as 1110.

Source files
------------

// File: rtl/bitwise_result_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_result_fifo_if
// Brief    : Result bus, push/pop handshakes and status readout for the
//            bitwise result FIFO.
// Revision : 1.0 - initial release
// ============================================================================
interface bitwise_result_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   d0;
    logic [WIDTH-1:0]   d1;
    logic [WIDTH-1:0]   d2;
    logic [WIDTH-1:0]   d3;
    logic [WIDTH-1:0]   d4;
    logic               in_valid;
    logic [2:0]         in_op;
    logic               in_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [2:0]         out_op;
    logic               out_ready;
    logic [c_CNT_W-1:0] count;
    logic [WIDTH-1:0]   checksum;
    logic               err_op;

    // Upstream/downstream environment side.
    modport master (
        output d0, d1, d2, d3, d4, in_valid, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_op, count, checksum, err_op
    );

    // FIFO side.
    modport slave (
        input  d0, d1, d2, d3, d4, in_valid, in_op, out_ready,
        output in_ready, out_valid, out_data, out_op, count, checksum, err_op
    );
endinterface
`default_nettype wire

// File: rtl/bitwise_result_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_result_fifo
// Brief    : Selects one bitwise result per accepted transfer and queues it
//            with its opcode in a first-word-fall-through FIFO. DEPTH must be
//            a power of two, >= 2.
// Revision : 1.0 - initial release
// ============================================================================
module bitwise_result_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    bitwise_result_fifo_if.slave bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_ENT_W = WIDTH + 3;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [2:0]         c_OP_MAX   = 3'd4;

    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [WIDTH-1:0]   r_checksum;
    logic               r_err_op;

    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_illegal;
    logic               w_push;
    logic               w_pop;
    logic [WIDTH-1:0]   w_sel;
    logic [c_ENT_W-1:0] w_head;

    // Handshake readiness depends on occupancy only, never on in_valid/out_ready.
    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_accept  = bus.in_valid && !w_full;
    assign w_illegal = (bus.in_op > c_OP_MAX);
    assign w_push    = w_accept && !w_illegal;
    assign w_pop     = bus.out_ready && !w_empty;

    always_comb begin
        w_sel = bus.d0;
        case (bus.in_op)
            3'd1:    w_sel = bus.d1;
            3'd2:    w_sel = bus.d2;
            3'd3:    w_sel = bus.d3;
            3'd4:    w_sel = bus.d4;
            default: w_sel = bus.d0;
        endcase
    end

    // Storage is cleared too so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.in_op, w_sel};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_checksum <= '0;
            r_err_op   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_checksum <= r_checksum ^ w_head[WIDTH-1:0];
            end
            if (w_accept && w_illegal) begin
                r_err_op <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_head[WIDTH-1:0];
    assign bus.out_op    = w_head[c_ENT_W-1:WIDTH];
    assign bus.count     = r_count;
    assign bus.checksum  = r_checksum;
    assign bus.err_op    = r_err_op;

endmodule
`default_nettype wire
